// File: rtl/bk_arb_pkg.sv
// Shared types and constants for the Brent-Kung adder arbiter slice.
// ADD_W/SUM_W fix the operand and result widths. bk_arb_state_e is the
// FSM encoding. wrap_inc advances the round-robin pointer.
package bk_arb_pkg;

  localparam int ADD_W = 12;
  localparam int SUM_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } bk_arb_state_e;

  typedef logic [ADD_W-1:0] bk_opnd_t;
  typedef logic [SUM_W-1:0] bk_sum_t;

  // (g + 1) mod n, without a divider
  function automatic int unsigned wrap_inc(input int unsigned g, input int unsigned n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/bk_adder12.sv
// 12-bit Brent-Kung parallel-prefix adder, purely combinational.
// Ports:
//   inputs [23:0] : interleaved operands, inputs[2i]=a[i], inputs[2i+1]=b[i]
//   outs   [12:0] : a+b, outs[12] = carry out
module bk_adder12
  import bk_arb_pkg::*;
(
  input  logic [2*ADD_W-1:0] inputs,
  output bk_sum_t            outs
);

  // Largest span used by the down-sweep tree
  localparam int unsigned TOP_D = 2 ** ($clog2(ADD_W) - 1);

  bk_opnd_t a, b, p, gg, pg;

  always_comb begin
    a  = '0;
    b  = '0;
    for (int unsigned i = 0; i < ADD_W; i++) begin
      a[i] = inputs[2*i];
      b[i] = inputs[2*i+1];
    end
    p  = a ^ b;
    gg = a & b;
    pg = p;

    // Up-sweep: node i combines with i-d where i = 2d-1 mod 2d
    for (int unsigned d = 1; d < ADD_W; d = d * 2) begin
      for (int unsigned i = 2*d - 1; i < ADD_W; i = i + 2*d) begin
        gg[i] = gg[i] | (pg[i] & gg[i-d]);
        pg[i] = pg[i] & pg[i-d];
      end
    end

    // Down-sweep: fill remaining prefixes from the completed ones
    for (int unsigned d = TOP_D; d >= 1; d = d / 2) begin
      for (int unsigned i = 3*d - 1; i < ADD_W; i = i + 2*d) begin
        gg[i] = gg[i] | (pg[i] & gg[i-d]);
        pg[i] = pg[i] & pg[i-d];
      end
    end

    outs    = '0;
    outs[0] = p[0];
    for (int unsigned i = 1; i < ADD_W; i++) begin
      outs[i] = p[i] ^ gg[i-1];
    end
    outs[ADD_W] = gg[ADD_W-1];
  end

endmodule

// File: rtl/bk_rr_arbiter.sv
// Request arbiter for bk_adder_arbiter.
// Default build: round-robin, search starts at ptr and wraps.
// With BK_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// ptr is ignored.
// Ports:
//   req     [N_REQ-1:0] : request vector
//   ptr     [ID_W-1:0]  : round-robin start index
//   en                  : grant enable; gnt is all-zero when low
//   gnt     [N_REQ-1:0] : one-hot grant
//   gnt_idx [ID_W-1:0]  : encoded winner (valid when gnt_any)
//   gnt_any             : a grant is issued this cycle
module bk_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_any
);

  logic found;

`ifdef BK_ARB_FIXED_PRIO_EN
  // Pointer is not part of the fixed-priority selection
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end
`else
  always_comb begin
    int unsigned idx;
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end
`endif

  always_comb begin
    gnt     = '0;
    gnt_any = en && found;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/bk_adder_arbiter.sv
// Shares one 12-bit Brent-Kung adder between N_REQ requesters, one
// operation in flight at a time. Accepted operands are registered into
// the adder. The 13-bit sum is returned with the owner's index.
// Optional macro BK_ARB_FIXED_PRIO_EN selects fixed priority instead of
// round-robin. The FSM, latency and ports are the same in both builds.
// Ports:
//   clk, rst_n           : clock (rising), async active-low reset
//   req_valid [N_REQ]    : per-requester valid
//   req_a/req_b [N_REQ*12] : operands, requester i at [12i+11:12i]
//   req_ready [N_REQ]    : one-hot combinational accept
//   rsp_valid/rsp_ready  : response handshake
//   rsp_sum [13]         : a+b with carry in bit 12
//   rsp_id  [ID_W]       : owner of rsp_sum
//   busy                 : FSM not in IDLE
module bk_adder_arbiter
  import bk_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*12-1:0] req_a,
  input  logic [N_REQ*12-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [12:0]        rsp_sum,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy
);

  bk_arb_state_e        state_q;
  bk_opnd_t             op_a_q, op_b_q;
  logic [ID_W-1:0]      id_q;
  bk_sum_t              rsp_sum_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic                 rsp_valid_q;

  logic [ID_W-1:0]      arb_ptr;
  logic                 grant_en;
  logic [N_REQ-1:0]     gnt;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_any;
  bk_opnd_t             sel_a, sel_b;
  logic [2*ADD_W-1:0]   add_in;
  bk_sum_t              add_sum;

  // rst_n term keeps req_ready low while reset is held, even though the
  // reset state is IDLE and would otherwise accept.
  assign grant_en = rst_n && ((state_q == IDLE) || (state_q == RESP && rsp_ready));

  bk_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (arb_ptr),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;
  assign sel_a     = req_a[int'(gnt_idx)*ADD_W +: ADD_W];
  assign sel_b     = req_b[int'(gnt_idx)*ADD_W +: ADD_W];

`ifdef BK_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [ID_W-1:0] ptr_q;
  assign arb_ptr = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= ID_W'(wrap_inc(int'(gnt_idx), N_REQ));
    end
  end
`endif

  always_comb begin
    add_in = '0;
    for (int unsigned i = 0; i < ADD_W; i++) begin
      add_in[2*i]   = op_a_q[i];
      add_in[2*i+1] = op_b_q[i];
    end
  end

  bk_adder12 u_add (
    .inputs (add_in),
    .outs   (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            id_q    <= gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= add_sum;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (gnt_any) begin
              op_a_q  <= sel_a;
              op_b_q  <= sel_b;
              id_q    <= gnt_idx;
              state_q <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule
